// File: rtl/scara_stepper_driver.sv
// scara_stepper_driver: step/direction pulse generator for the two SCARA joint steppers.
// Optional Bresenham joint synchronisation is enabled by defining SCARA_STEP_SYNC_EN.
module scara_stepper_driver #(
    parameter int HALF_PERIOD = 2500,
    parameter int DIR_SETUP   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] steps1,
    input  logic [7:0] steps2,
    input  logic       dir1,
    input  logic       dir2,
    input  logic       dataReady,
    input  logic       halt,
    output logic       step1,
    output logic       step2,
    output logic       dirOut1,
    output logic       dirOut2,
    output logic       busy,
    output logic       stepperReady
);
    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int SW = $clog2(DIR_SETUP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
    state_t state, nxt;

    logic [HW-1:0] ht;
    logic [SW-1:0] st;
    logic [7:0]    cnt1, cnt2, periods;
    logic          fire1, fire2, stop, started, boot, enter_high;

`ifdef SCARA_STEP_SYNC_EN
    logic [8:0] err, acc;
    logic [7:0] nmaj, nmin;
    logic       maj1, hit;
    // Joint 1 is the major joint on a tie; the minor joint fires when the accumulator overflows.
    always_comb begin
        maj1 = cnt1 >= cnt2;
        nmaj = maj1 ? cnt1 : cnt2;
        nmin = maj1 ? cnt2 : cnt1;
        acc  = err + {1'b0, nmin};
        hit  = acc >= {1'b0, nmaj};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !dataReady ? IDLE : ((steps1 | steps2) == 8'd0) ? DONE : SETUP;
            SETUP:   nxt = halt ? DONE : (st == '0) ? HIGH : SETUP;
            HIGH:    nxt = (ht == '0) ? LOW : HIGH;
            LOW:     nxt = (ht != '0) ? LOW : (stop || halt || periods == 8'd1) ? DONE : HIGH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign enter_high = (nxt == HIGH) && (state != HIGH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ht      <= '0;
            st      <= '0;
            cnt1    <= '0;
            cnt2    <= '0;
            periods <= '0;
            fire1   <= 1'b0;
            fire2   <= 1'b0;
            stop    <= 1'b0;
            started <= 1'b0;
            boot    <= 1'b0;
            dirOut1 <= 1'b0;
            dirOut2 <= 1'b0;
`ifdef SCARA_STEP_SYNC_EN
            err     <= '0;
`endif
        end else begin
            // Announce readiness once, on the first edge after reset release.
            started <= 1'b1;
            boot    <= ~started;
            if (state == IDLE && dataReady) begin
                cnt1    <= steps1;
                cnt2    <= steps2;
                periods <= (steps1 >= steps2) ? steps1 : steps2;
                dirOut1 <= dir1;
                dirOut2 <= dir2;
                stop    <= 1'b0;
                st      <= SW'(DIR_SETUP - 1);
`ifdef SCARA_STEP_SYNC_EN
                err     <= '0;
`endif
            end
            if (state == SETUP) st <= st - SW'(1);
            // A halt seen mid-period lets the current pulse finish cleanly.
            if ((state == HIGH || state == LOW) && halt) stop <= 1'b1;
            if (nxt == HIGH || nxt == LOW) ht <= (nxt != state) ? HW'(HALF_PERIOD - 1) : ht - HW'(1);
            if (state == LOW && ht == '0 && periods != 8'd0) periods <= periods - 8'd1;
            if (enter_high) begin
`ifdef SCARA_STEP_SYNC_EN
                fire1 <= maj1 | hit;
                fire2 <= ~maj1 | hit;
                err   <= hit ? acc - {1'b0, nmaj} : acc;
`else
                fire1 <= cnt1 != 8'd0;
                fire2 <= cnt2 != 8'd0;
                if (cnt1 != 8'd0) cnt1 <= cnt1 - 8'd1;
                if (cnt2 != 8'd0) cnt2 <= cnt2 - 8'd1;
`endif
            end
        end
    end

    assign step1        = (state == HIGH) && fire1;
    assign step2        = (state == HIGH) && fire2;
    assign busy         = state inside {SETUP, HIGH, LOW};
    assign stepperReady = (state == DONE) || boot;
endmodule

// File: tb/tb_scara_stepper_driver.sv
// tb_scara_stepper_driver: table-driven move commands with a completion scoreboard,
// plus hand sequences for halt, ignored commands and mid-move reset.
module tb_scara_stepper_driver;
    localparam int HP = 4;
    localparam int DS = 2;
`ifdef SCARA_STEP_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] steps1 = '0, steps2 = '0;
    logic       dir1 = 1'b0, dir2 = 1'b0, dataReady = 1'b0, halt = 1'b0;
    logic       step1, step2, dirOut1, dirOut2, busy, stepperReady;

    always #5 clk = ~clk;

    scara_stepper_driver #(.HALF_PERIOD(HP), .DIR_SETUP(DS)) dut (
        .clk(clk), .reset(reset), .steps1(steps1), .steps2(steps2), .dir1(dir1), .dir2(dir2),
        .dataReady(dataReady), .halt(halt), .step1(step1), .step2(step2), .dirOut1(dirOut1),
        .dirOut2(dirOut2), .busy(busy), .stepperReady(stepperReady)
    );

    typedef struct {
        int          lat, e1, e2;
        logic [15:0] m1, m2;
        logic [1:0]  dir;
        bit          bz;
    } exp_t;

    typedef struct {
        logic [7:0]  s1, s2;
        logic        d1, d2;
        int          lat, e1, e2;
        logic [15:0] m1, m2;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          checks = 0, errors = 0, cyc = 0, t0 = 0, p1 = 0, p2 = 0;
    logic [15:0] m1 = '0, m2 = '0;
    bit          bz = 0, s1q = 0, s2q = 0, mon_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic clr();
        p1 = 0; p2 = 0; m1 = '0; m2 = '0; bz = 0;
    endtask

    // Advance to the next falling edge and record what the DUT did during that cycle.
    task automatic tick();
        exp_t e;
        int   idx;
        @(negedge clk);
        cyc++;
        idx = (cyc - t0 - 1 - DS) / (2 * HP);
        if (!reset) begin
            clr(); s1q = 0; s2q = 0;
        end else begin
            if (step1 && !s1q) begin p1++; if (cyc - t0 >= 1 + DS && idx < 16) m1[idx] = 1'b1; end
            if (step2 && !s2q) begin p2++; if (cyc - t0 >= 1 + DS && idx < 16) m2[idx] = 1'b1; end
            s1q = step1; s2q = step2;
            if (busy) bz = 1;
            if (stepperReady) begin
                if (mon_en) begin
                    if (sb.size() == 0) chk("unexpected_ready", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("latency", cyc - t0, e.lat);
                        chk("pulses1", p1, e.e1);
                        chk("pulses2", p2, e.e2);
                        chk("periods1", int'(m1), int'(e.m1));
                        chk("periods2", int'(m2), int'(e.m2));
                        chk("dir_out", int'({dirOut1, dirOut2}), int'(e.dir));
                        chk("busy_seen", int'(bz), int'(e.bz));
                    end
                end
                clr();
            end
        end
    endtask

    task automatic cmd(input logic [7:0] s1, input logic [7:0] s2, input logic d1, input logic d2,
                       input int lat, input int e1, input int e2, input logic [15:0] x1, input logic [15:0] x2);
        exp_t e;
        tick();
        steps1 = s1; steps2 = s2; dir1 = d1; dir2 = d2; dataReady = 1'b1;
        t0 = cyc;
        e = '{lat, e1, e2, x1, x2, {d1, d2}, (s1 | s2) != 8'd0};
        sb.push_back(e);
        tick();
        dataReady = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            chk("completion_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        vecs[0] = '{8'd3,   8'd0, 1'b1, 1'b0,   27,   3, 0, 16'h0007, 16'h0000};
        vecs[1] = '{8'd8,   8'd4, 1'b0, 1'b1,   67,   8, 4, 16'h00FF, SYNC ? 16'h00AA : 16'h000F};
        vecs[2] = '{8'd0,   8'd0, 1'b1, 1'b1,    1,   0, 0, 16'h0000, 16'h0000};
        vecs[3] = '{8'd4,   8'd8, 1'b1, 1'b1,   67,   4, 8, SYNC ? 16'h00AA : 16'h000F, 16'h00FF};
        vecs[4] = '{8'd1,   8'd1, 1'b0, 1'b0,   11,   1, 1, 16'h0001, 16'h0001};
        vecs[5] = '{8'd255, 8'd7, 1'b1, 1'b0, 2043, 255, 7, 16'hFFFF, SYNC ? 16'h0000 : 16'h007F};
        vecs[6] = '{8'd5,   8'd5, 1'b0, 1'b1,   43,   5, 5, 16'h001F, 16'h001F};
        vecs[7] = '{8'd0,   8'd6, 1'b1, 1'b0,   51,   0, 6, 16'h0000, 16'h003F};

        tick(); tick();
        chk("reset_outputs", int'({step1, step2, dirOut1, dirOut2, busy, stepperReady}), 0);
        reset = 1'b1;
        tick();
        chk("boot_ready_high", int'(stepperReady), 1);
        tick();
        chk("boot_ready_low", int'(stepperReady), 0);
        chk("idle_busy", int'(busy), 0);
        mon_en = 1;

        for (int i = 0; i < 8; i++) begin
            cmd(vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2, vecs[i].lat, vecs[i].e1, vecs[i].e2, vecs[i].m1, vecs[i].m2);
            wait_done();
        end

        // halt during the HIGH phase of period 2 of a 5-step move
        cmd(8'd5, 8'd0, 1'b0, 1'b1, 19, 2, 0, 16'h0003, 16'h0000);
        while (cyc < t0 + 12) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        wait_done();

        // a second command while busy is dropped
        cmd(8'd2, 8'd0, 1'b1, 1'b0, 19, 2, 0, 16'h0003, 16'h0000);
        repeat (4) tick();
        steps1 = 8'd9; steps2 = 8'd9; dir1 = 1'b0; dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
        wait_done();
        repeat (3) tick();

        // asynchronous reset in the middle of a pulse
        mon_en = 0;
        steps1 = 8'd5; steps2 = 8'd0; dir1 = 1'b1; dataReady = 1'b1;
        t0 = cyc;
        tick();
        dataReady = 1'b0;
        repeat (3) tick();
        chk("pre_reset_step1", int'(step1), 1);
        #1 reset = 1'b0;
        #1 chk("async_reset_outputs", int'({step1, step2, dirOut1, dirOut2, busy, stepperReady}), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rerelease_ready_high", int'(stepperReady), 1);
        tick();
        chk("rerelease_ready_low", int'(stepperReady), 0);
        repeat (20) tick();
        chk("no_pulse_after_reset", int'(step1) + p1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scara_stepper_driver.md
Name: scara_stepper_driver

Overview:
- Downstream of the SCARA controller.
- Consumes each move command: the per-joint 8-bit step counts, direction bits and the one-cycle dataReady strobe.
- Drives the step and direction pins of the two joint stepper drivers.
- Returns a one-cycle stepperReady pulse when a move completes; this pulse sets the controller's ready-for-new-data latch.

Parameters:
- HALF_PERIOD, 2500, clk cycles that each step pulse is high, and likewise low (must be >= 1).
- DIR_SETUP, 50, clk cycles that the direction pins are held stable before the first step edge (must be >= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- steps1  in  8  unsigned step count, joint 1.
- steps2  in  8  unsigned step count, joint 2.
- dir1  in  1  direction, joint 1.
- dir2  in  1  direction, joint 2.
- dataReady  in  1  one-cycle command strobe.
- halt  in  1  level; abort the current move.
- step1  out  1  step pulse, joint 1.
- step2  out  1  step pulse, joint 2.
- dirOut1  out  1  registered direction, joint 1.
- dirOut2  out  1  registered direction, joint 2.
- busy  out  1  high while a move is in progress.
- stepperReady  out  1  one-cycle move-complete pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - step1, step2, dirOut1, dirOut2, busy and all counters are 0.
  - stepperReady is 0.
  - Reset mid-move aborts the move immediately; no further pulses are issued.
- After reset release: stepperReady pulses high for exactly one cycle on the first clk edge, so the controller sees the driver as ready.
- State machine: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - dataReady is sampled at cycle T; steps1, steps2, dir1 and dir2 are latched.
  - If both counts are 0, go to DONE at T+1.
  - Otherwise go to SETUP at T+1, with dirOut valid and busy=1 from T+1.
  - dataReady outside IDLE is ignored; the command is dropped.
- SETUP: lasts DIR_SETUP cycles, then HIGH.
- Step periods:
  - One period = HIGH for HALF_PERIOD cycles, then LOW for HALF_PERIOD cycles.
  - Period count N = max(steps1, steps2).
  - A joint's step pin is high during HIGH only if that joint fires in the current period; otherwise it stays 0.
  - After the LOW phase of period N, go to DONE.
- DONE:
  - Lasts exactly 1 cycle with stepperReady=1 and busy=0.
  - Next state is IDLE.
  - Completion cycle for a non-zero move = T + 1 + DIR_SETUP + 2*HALF_PERIOD*N.
- dirOut1 and dirOut2 hold their latched values until the next accepted command.
- halt:
  - Sampled every cycle.
  - If high in SETUP, go to DONE next cycle.
  - If high in HIGH, finish the current HIGH and LOW phases (no truncated pulse), then go to DONE.
  - If high in LOW, finish the current LOW phase, then go to DONE.
  - halt in IDLE has no effect.
- Counters:
  - Each joint's remaining-step counter is 8 bits, unsigned; counters never wrap.
  - The half-period timer is sized $clog2(HALF_PERIOD+1) bits.
  - The setup timer is sized $clog2(DIR_SETUP+1) bits.
- A joint with count 255 emits exactly 255 pulses.
- Total pulses on stepN always equal the latched stepsN, except when a move is aborted by halt or reset.

Optional Feature:
- Macro: SCARA_STEP_SYNC_EN.
- Defined: Bresenham interpolation.
  - The major joint (larger count; joint 1 on a tie) fires every period.
  - The minor joint uses a 9-bit accumulator err, starting at 0.
  - Each period: err += nMinor; if err >= nMajor, the minor joint fires in that period and err -= nMajor.
  - Both joints finish in the same period.
- Undefined: joint k fires in periods 1..stepsk only; the shorter move ends early, while the state machine still runs N periods.

Test Plan (HALF_PERIOD=4, DIR_SETUP=2 unless noted):
- Reset released -> stepperReady=1 for exactly one cycle; all other outputs 0.
- dataReady at T with steps1=3, steps2=0, dir1=1 -> dirOut1=1 at T+1; step1 rises at T+3, three 4-high/4-low pulses, step2 stays 0; stepperReady at T+27.
- Sync defined; steps1=8, steps2=4 -> step1 fires in periods 1-8, step2 in periods 2, 4, 6, 8 only.
- Sync undefined; same command -> step2 fires in periods 1-4; stepperReady still at T+67.
- steps1=0, steps2=0 -> stepperReady at T+1; no step pulses; busy never asserted.
- halt asserted during the HIGH phase of period 2 of a 5-step move -> period 2 completes, exactly 2 pulses, then a single stepperReady pulse. Mid-move reset -> outputs 0 asynchronously; stepperReady one cycle after release. dataReady during busy -> ignored.
